fifo_share_ctrl: RTL and testbench

//  Shares one sync_fifo instance (no full/empty flags) between two producer streams and one consumer.

---
 rtl/fifo_share_ctrl_pkg.sv | 13 +
 rtl/fifo_share_ctrl_fifo.sv | 50 +++++
 rtl/fifo_share_ctrl.sv | 137 +++++++++++++
 tb/tb_fifo_share_ctrl.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_share_ctrl_pkg.sv
// Shared types for the two-producer FIFO sharing controller.
// Holds the write-side FSM state encoding and the producer grant codes.
package fifo_share_ctrl_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } fsm_state_t;

    localparam logic GNT_P0 = 1'b0;
    localparam logic GNT_P1 = 1'b1;

endpackage

// File: rtl/fifo_share_ctrl_fifo.sv
// Flagless synchronous FIFO used by fifo_share_ctrl; registered read data.
// Ports: clk, sys_rst_n, wr_en/data_in (write), rd_en/data_out (read, 1-cycle).
module fifo_share_ctrl_fifo #(
    parameter int DATA_LEN   = 8,
    parameter int DEPTH      = 8,
    parameter int ADDR_WIDTH = 3
) (
    input  logic                clk,
    input  logic                sys_rst_n,
    input  logic                wr_en,
    input  logic [DATA_LEN-1:0] data_in,
    input  logic                rd_en,
    output logic [DATA_LEN-1:0] data_out
);

    logic [DATA_LEN-1:0]   mem [DEPTH];
    logic [ADDR_WIDTH-1:0] wptr;
    logic [ADDR_WIDTH-1:0] rptr;

    // Pointers wrap at DEPTH-1 so DEPTH need not be a power of two.
    function automatic logic [ADDR_WIDTH-1:0] ptr_inc(
        input logic [ADDR_WIDTH-1:0] p
    );
        return (p == ADDR_WIDTH'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wptr] <= data_in;
        end
    end

    always_ff @(posedge clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            wptr     <= '0;
            rptr     <= '0;
            data_out <= '0;
        end else begin
            if (wr_en) begin
                wptr <= ptr_inc(wptr);
            end
            if (rd_en) begin
                rptr <= ptr_inc(rptr);
                // Same-slot read and write: hand the incoming word straight out.
                data_out <= (wr_en && (rptr == wptr)) ? data_in : mem[rptr];
            end
        end
    end

endmodule

// File: rtl/fifo_share_ctrl.sv
// Shares one flagless FIFO between two producers (round-robin bursts) and one consumer.
// Ports: clk, sys_rst_n; p0/p1 valid/data/ready; rd_req; out_valid/out_data; count/full/empty.
// Config: define FIFO_BYPASS_EN to let an empty FIFO read and write in the same cycle.
module fifo_share_ctrl
    import fifo_share_ctrl_pkg::*;
#(
    parameter int DATA_LEN   = 8,
    parameter int DEPTH      = 8,
    parameter int ADDR_WIDTH = 3,
    parameter int MAX_BURST  = 4
) (
    input  logic                clk,
    input  logic                sys_rst_n,
    input  logic                p0_valid,
    input  logic [DATA_LEN-1:0] p0_data,
    output logic                p0_ready,
    input  logic                p1_valid,
    input  logic [DATA_LEN-1:0] p1_data,
    output logic                p1_ready,
    input  logic                rd_req,
    output logic                out_valid,
    output logic [DATA_LEN-1:0] out_data,
    output logic [ADDR_WIDTH:0] count,
    output logic                full,
    output logic                empty
);

    localparam int CW = ADDR_WIDTH + 1;
    localparam int BW = $clog2(MAX_BURST + 1);

    fsm_state_t          state;
    logic                owner;
    logic                last_grant;
    logic                gnt;
    logic                in_valid;
    logic                wr_en;
    logic                rd_en;
    logic                burst_end;
    logic [BW-1:0]       burst_cnt;
    logic [BW-1:0]       cnt_inc;
    logic [DATA_LEN-1:0] wr_data;

    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);

    // In IDLE pick a producer; in BURST the owner keeps the grant.
    always_comb begin
        gnt = owner;
        if (state == ST_IDLE) begin
            if (p0_valid && p1_valid) begin
                gnt = ~last_grant;
            end else if (p1_valid) begin
                gnt = GNT_P1;
            end else begin
                gnt = GNT_P0;
            end
        end
    end

    assign in_valid  = (gnt == GNT_P1) ? p1_valid : p0_valid;
    assign wr_data   = (gnt == GNT_P1) ? p1_data : p0_data;
    assign wr_en     = in_valid & ~full;
    assign p0_ready  = wr_en & (gnt == GNT_P0);
    assign p1_ready  = wr_en & (gnt == GNT_P1);
    assign cnt_inc   = burst_cnt + 1'b1;
    // Beat about to be taken is the last one allowed in this burst.
    assign burst_end = (cnt_inc == BW'(MAX_BURST));

`ifdef FIFO_BYPASS_EN
    assign rd_en = rd_req & (~empty | wr_en);
`else
    assign rd_en = rd_req & ~empty;
`endif

    always_ff @(posedge clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state      <= ST_IDLE;
            owner      <= GNT_P0;
            last_grant <= GNT_P1;
            burst_cnt  <= '0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (wr_en) begin
                        owner <= gnt;
                        if (burst_end) begin
                            last_grant <= gnt;
                        end else begin
                            state     <= ST_BURST;
                            burst_cnt <= cnt_inc;
                        end
                    end
                end
                ST_BURST: begin
                    if (!in_valid || (wr_en && burst_end)) begin
                        state      <= ST_IDLE;
                        last_grant <= owner;
                        burst_cnt  <= '0;
                    end else if (wr_en) begin
                        burst_cnt <= cnt_inc;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            count     <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= rd_en;
            unique case ({wr_en, rd_en})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    fifo_share_ctrl_fifo #(
        .DATA_LEN   (DATA_LEN),
        .DEPTH      (DEPTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_fifo (
        .clk       (clk),
        .sys_rst_n (sys_rst_n),
        .wr_en     (wr_en),
        .data_in   (wr_data),
        .rd_en     (rd_en),
        .data_out  (out_data)
    );

endmodule

// File: tb/tb_fifo_share_ctrl.sv
// Self-checking bench for fifo_share_ctrl: directed cases plus random traffic.
// Reference: word queue scoreboard, occupancy from queue size, fairness bounds.
module tb_fifo_share_ctrl;

    localparam int DL    = 8;
    localparam int DEPTH = 8;
    localparam int AW    = 3;
    localparam int MB    = 4;
`ifdef FIFO_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          sys_rst_n = 1'b0;
    logic          p0_valid = 1'b0;
    logic [DL-1:0] p0_data = '0;
    logic          p0_ready;
    logic          p1_valid = 1'b0;
    logic [DL-1:0] p1_data = '0;
    logic          p1_ready;
    logic          rd_req = 1'b0;
    logic          out_valid;
    logic [DL-1:0] out_data;
    logic [AW:0]   count;
    logic          full;
    logic          empty;

    int checks = 0;
    int failures = 0;

    logic [DL-1:0] q[$];
    logic [DL-1:0] src0[$];
    logic [DL-1:0] src1[$];
    int            acc[$];
    logic          r0, r1;
    int            wb0, wb1, maxb, wc0, wc1, maxc;
    logic [DL-1:0] nxt = 8'h00;

    always #5 clk = ~clk;

    fifo_share_ctrl #(
        .DATA_LEN   (DL),
        .DEPTH      (DEPTH),
        .ADDR_WIDTH (AW),
        .MAX_BURST  (MB)
    ) dut (
        .clk       (clk),
        .sys_rst_n (sys_rst_n),
        .p0_valid  (p0_valid),
        .p0_data   (p0_data),
        .p0_ready  (p0_ready),
        .p1_valid  (p1_valid),
        .p1_data   (p1_data),
        .p1_ready  (p1_ready),
        .rd_req    (rd_req),
        .out_valid (out_valid),
        .out_data  (out_data),
        .count     (count),
        .full      (full),
        .empty     (empty)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic clear_model();
        q.delete();
        src0.delete();
        src1.delete();
        acc.delete();
        wb0 = 0; wb1 = 0; wc0 = 0; wc1 = 0;
    endtask

    task automatic do_reset();
        sys_rst_n = 1'b0;
        p0_valid = 1'b0;
        p1_valid = 1'b0;
        rd_req = 1'b0;
        clear_model();
        repeat (2) @(posedge clk);
        @(negedge clk);
        sys_rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // One clock: drive at posedge+1, sample at negedge, check outputs at posedge+1.
    task automatic step(input bit e0, input bit e1, input bit rq);
        int pre;
        bit b0, b1, exp_rd, was_full;
        logic [DL-1:0] exp_od;
        p0_valid = e0 && (src0.size() > 0);
        p0_data  = (src0.size() > 0) ? src0[0] : '0;
        p1_valid = e1 && (src1.size() > 0);
        p1_data  = (src1.size() > 0) ? src1[0] : '0;
        rd_req   = rq;
        @(negedge clk);
        r0 = p0_ready;
        r1 = p1_ready;
        b0 = p0_valid && p0_ready;
        b1 = p1_valid && p1_ready;
        pre = q.size();
        was_full = (pre == DEPTH);
        chk("one_ready", 32'(r0 & r1), 32'd0);
        chk("count", 32'(count), 32'(pre));
        chk("full", 32'(full), 32'(was_full));
        chk("empty", 32'(empty), 32'(pre == 0));
        if (was_full) chk("ready_when_full", 32'(r0 | r1), 32'd0);
        if (!p1_valid || b1) wb1 = 0; else if (b0) wb1++;
        if (!p0_valid || b0) wb0 = 0; else if (b1) wb0++;
        if (!p1_valid || b1) wc1 = 0; else if (!was_full) wc1++;
        if (!p0_valid || b0) wc0 = 0; else if (!was_full) wc0++;
        maxb = (wb0 > maxb) ? wb0 : maxb;
        maxb = (wb1 > maxb) ? wb1 : maxb;
        maxc = (wc0 > maxc) ? wc0 : maxc;
        maxc = (wc1 > maxc) ? wc1 : maxc;
        if (b0) begin q.push_back(p0_data); acc.push_back(0); end
        if (b1) begin q.push_back(p1_data); acc.push_back(1); end
        exp_rd = rq && (BYP ? (q.size() > 0) : (pre > 0));
        exp_od = '0;
        if (exp_rd) exp_od = q.pop_front();
        @(posedge clk);
        #1;
        chk("out_valid", 32'(out_valid), 32'(exp_rd));
        if (exp_rd) chk("out_data", 32'(out_data), 32'(exp_od));
        if (b0) void'(src0.pop_front());
        if (b1) void'(src1.pop_front());
    endtask

    initial begin
        int n;
        int exp_src[12];
        int pct[6];
        maxb = 0;
        maxc = 0;

        // Reset state
        do_reset();
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_ready", 32'({p0_ready, p1_ready}), 32'd0);

        // p0 alone fills the FIFO, then the consumer drains it in order
        for (int i = 0; i < 8; i++) src0.push_back(8'(8'h10 + i));
        for (int i = 0; i < 8; i++) begin
            step(1, 0, 0);
            chk("fill_p0_ready", 32'(r0), 32'd1);
        end
        chk("fill_count", 32'(count), 32'd8);
        chk("fill_full", 32'(full), 32'd1);
        for (int i = 0; i < 8; i++) step(0, 0, 1);
        chk("drain_empty", 32'(empty), 32'd1);

        // Both producers with work: bursts of MB, alternating from p0
        do_reset();
        for (int i = 0; i < 8; i++) src0.push_back(8'(8'h20 + i));
        for (int i = 0; i < 4; i++) src1.push_back(8'(8'h40 + i));
        n = 0;
        while ((src0.size() + src1.size()) > 0 && n < 100) begin
            step(1, 1, 1);
            n++;
        end
        while (q.size() > 0 && n < 120) begin
            step(0, 0, 1);
            n++;
        end
        chk("rr_done", 32'(src0.size() + src1.size() + q.size()), 32'd0);
        chk("rr_beats", 32'(acc.size()), 32'd12);
        exp_src = '{0, 0, 0, 0, 1, 1, 1, 1, 0, 0, 0, 0};
        for (int i = 0; i < 12; i++) begin
            if (i < acc.size()) chk("rr_order", 32'(acc[i]), 32'(exp_src[i]));
        end

        // Full: simultaneous p1 word and read -> read only
        do_reset();
        for (int i = 0; i < 8; i++) src0.push_back(8'(8'h50 + i));
        for (int i = 0; i < 8; i++) step(1, 0, 0);
        src1.push_back(8'h99);
        step(0, 1, 1);
        chk("full_p1_ready", 32'(r1), 32'd0);
        chk("full_count", 32'(count), 32'd7);
        chk("full_oldest", 32'(out_data), 32'h50);
        step(0, 1, 0);
        chk("after_full_p1", 32'(r1), 32'd1);

        // Empty FIFO, read and write in the same cycle
        do_reset();
        src0.push_back(8'hA5);
        step(1, 0, 1);
`ifdef FIFO_BYPASS_EN
        chk("byp_out_valid", 32'(out_valid), 32'd1);
        chk("byp_out_data", 32'(out_data), 32'hA5);
        chk("byp_count", 32'(count), 32'd0);
`else
        chk("nobyp_out_valid", 32'(out_valid), 32'd0);
        chk("nobyp_count", 32'(count), 32'd1);
`endif

        // Asynchronous reset in the middle of a burst
        do_reset();
        for (int i = 0; i < 7; i++) src0.push_back(8'(8'h60 + i));
        for (int i = 0; i < 5; i++) step(1, 0, 0);
        chk("pre_rst_count", 32'(count), 32'd5);
        sys_rst_n = 1'b0;
        #1;
        chk("mid_rst_count", 32'(count), 32'd0);
        chk("mid_rst_empty", 32'(empty), 32'd1);
        chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
        p0_valid = 1'b0;
        clear_model();
        @(negedge clk);
        sys_rst_n = 1'b1;
        @(posedge clk);
        #1;
        src1.push_back(8'h77);
        step(0, 1, 0);
        chk("rst_p1_first", 32'(r1), 32'd1);

        // Random traffic against the scoreboard
        do_reset();
        maxb = 0;
        maxc = 0;
        pct = '{30, 70, 50, 90, 20, 60};
        for (int c = 0; c < 3000; c++) begin
            if (src0.size() < 3 && $urandom_range(0, 1) == 0) begin
                src0.push_back(nxt);
                nxt = nxt + 8'd1;
            end
            if (src1.size() < 3 && $urandom_range(0, 1) == 0) begin
                src1.push_back(nxt);
                nxt = nxt + 8'd1;
            end
            step($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
                 $urandom_range(0, 99) < pct[c / 500]);
        end
        n = 0;
        while (q.size() > 0 && n < 20) begin
            step(0, 0, 1);
            n++;
        end
        chk("rand_drained", 32'(q.size()), 32'd0);
        chk("burst_bound", 32'(maxb <= MB), 32'd1);
        chk("wait_bound", 32'(maxc <= 2 * MB + 2), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
